// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream and instruction-memory write bundle for imem_loader
//
// Purpose: groups the host byte-stream handshake and the instruction-memory write port.
// Signal suffixes are written from the loader's point of view.
//   byte_valid_i  host -> loader  byte_data_i is valid
//   byte_data_i   host -> loader  next image byte
//   byte_ready_o  loader -> host  loader accepts a byte this cycle
//   mem_we_o      loader -> mem   write enable, one pulse per word
//   mem_addr_o    loader -> mem   word address
//   mem_wdata_o   loader -> mem   packed instruction word
// Modports: slave = the loader, master = the host/memory side.
interface imem_loader_if #(
    parameter int ADDR_W = 6
);
    logic              byte_valid_i;
    logic [7:0]        byte_data_i;
    logic              byte_ready_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;

    modport slave (
        input  byte_valid_i,
        input  byte_data_i,
        output byte_ready_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o
    );

    modport master (
        output byte_valid_i,
        output byte_data_i,
        input  byte_ready_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o
    );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - packs a host byte stream into 32-bit words and writes them to instruction memory
//
// Purpose: write side of the instruction memory. Every 4 accepted bytes form one word
// (first byte in bits 31:24) written to consecutive addresses from 0. busy_o keeps the
// core stalled while an image is being loaded.
// Ports:
//   clk_i    in   clock, rising edge
//   rst_n_i  in   asynchronous active-low reset
//   start_i  in   1-cycle request opening a load session
//   len_i    in   words to load (1..DEPTH), sampled with start_i
//   bus      slave modport of imem_loader_if (byte stream + memory write port)
//   busy_o   out  session in progress
//   done_o   out  1-cycle pulse when the session finishes
//   err_o    out  sticky: last start_i carried an illegal len_i
module imem_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic [ADDR_W:0]   len_i,
    imem_loader_if.slave      bus,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [31:0]       word_q, word_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              ready_q, we_q, busy_q, done_q;

    logic byte_fire;
    logic len_ok;
    logic last_word;

    // ready_q is high exactly when the FSM sits in LOAD, so it doubles as the state qualifier.
    assign byte_fire = bus.byte_valid_i && ready_q;
    assign len_ok    = (len_i != '0) && (len_i <= DEPTH_L);
    assign last_word = ({1'b0, addr_q} == (len_q - ONE_L));

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        addr_d      = addr_q;
        bcnt_d      = bcnt_q;
        word_d      = word_q;
        err_d       = err_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (len_ok) begin
                        len_d   = len_i;
                        addr_d  = '0;
                        bcnt_d  = 2'd0;
                        err_d   = 1'b0;
                        state_d = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (byte_fire) begin
                    word_d = {word_q[23:0], bus.byte_data_i};
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        // Capture the write port now so it is registered during WRITE.
                        mem_addr_d  = addr_q;
                        mem_wdata_d = {word_q[23:0], bus.byte_data_i};
                        state_d     = WRITE;
                    end
                end
            end
            WRITE: begin
                if (last_word) begin
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = LOAD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            len_q       <= '0;
            addr_q      <= '0;
            bcnt_q      <= 2'd0;
            word_q      <= '0;
            err_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ready_q     <= 1'b0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            bcnt_q      <= bcnt_d;
            word_q      <= word_d;
            err_q       <= err_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            // Outputs are decoded from the next state so they line up with state_q.
            ready_q     <= (state_d == LOAD);
            we_q        <= (state_d == WRITE);
            busy_q      <= (state_d == LOAD) || (state_d == WRITE);
            done_q      <= (state_d == DONE);
        end
    end

    assign bus.byte_ready_o = ready_q;
    assign bus.mem_we_o     = we_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.mem_wdata_o  = mem_wdata_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign err_o            = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

    localparam int ADDR_W = 6;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [ADDR_W:0] len = '0;
    logic            busy, done, err;

    int total = 0;
    int bad   = 0;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.DEPTH(64), .ADDR_W(ADDR_W)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .start_i (start),
        .len_i   (len),
        .bus     (bus.slave),
        .busy_o  (busy),
        .done_o  (done),
        .err_o   (err)
    );

    always #5 clk = ~clk;

    // Write log, captured away from the active edge.
    logic [ADDR_W-1:0] log_addr[$];
    logic [31:0]       log_data[$];
    int cyc = 0;
    int done_cnt = 0;
    int last_we_cyc = 0;
    int last_done_cyc = 0;
    int we_with_ready = 0;
    int done_with_busy = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.mem_we_o) begin
            log_addr.push_back(bus.mem_addr_o);
            log_data.push_back(bus.mem_wdata_o);
            last_we_cyc = cyc;
            if (bus.byte_ready_o) we_with_ready++;
        end
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
            if (busy) done_with_busy++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [ADDR_W:0] l);
        start = 1'b1;
        len   = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Presents one byte and returns #1 after the edge on which it transferred.
    // byte_valid is left high so callers can chain bytes back-to-back.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.byte_valid_i = 1'b1;
        bus.byte_data_i  = b;
        @(negedge clk);
        while (!bus.byte_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.byte_ready_o) chk("byte_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic idle_cycles(input int n);
        bus.byte_valid_i = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done(input int prev, input string tag);
        int n;
        n = 0;
        while (done_cnt == prev && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, done_cnt, prev + 1);
        @(posedge clk); #1;
    endtask

    logic [7:0]  img2[8]   = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    logic [31:0] exp3[3]   = '{32'hDEADBEEF, 32'h01020304, 32'hCAFEF00D};
    int          gaps[12]  = '{0, 2, 1, 0, 3, 0, 1, 0, 0, 2, 0, 1};

    initial begin
        int d0;
        logic [31:0] w;
        bus.byte_valid_i = 1'b0;
        bus.byte_data_i  = 8'h00;

        // Reset state
        #12;
        chk("rst_ready", bus.byte_ready_o, 1'b0);
        chk("rst_busy",  busy, 1'b0);
        chk("rst_we",    bus.mem_we_o, 1'b0);
        chk("rst_err",   err, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: reset mid-session after 2 bytes of word 1
        do_start(7'd2);
        chk("t1_busy", busy, 1'b1);
        send_byte(8'hAA);
        send_byte(8'hBB);
        bus.byte_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t1_rst_ready", bus.byte_ready_o, 1'b0);
        chk("t1_rst_busy",  busy, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_cycles(3);
        chk("t1_ready_after", bus.byte_ready_o, 1'b0);
        chk("t1_no_writes", log_data.size(), 0);

        // 2: len=2, back-to-back bytes
        d0 = done_cnt;
        do_start(7'd2);
        foreach (img2[i]) send_byte(img2[i]);
        bus.byte_valid_i = 1'b0;
        wait_done(d0, "t2_done");
        chk("t2_nwrites", log_data.size(), 2);
        if (log_data.size() == 2) begin
            chk("t2_a0", log_addr[0], 6'd0);
            chk("t2_d0", log_data[0], 32'h12345678);
            chk("t2_a1", log_addr[1], 6'd1);
            chk("t2_d1", log_data[1], 32'h9ABCDEF0);
        end
        chk("t2_done_lat", last_done_cyc - last_we_cyc, 1);
        chk("t2_busy_end", busy, 1'b0);
        log_addr.delete(); log_data.delete();

        // 3: illegal lengths, then a legal one
        d0 = done_cnt;
        do_start(7'd0);
        chk("t3_err0", err, 1'b1);
        chk("t3_ready0", bus.byte_ready_o, 1'b0);
        idle_cycles(2);
        do_start(7'd65);
        chk("t3_err65", err, 1'b1);
        idle_cycles(2);
        chk("t3_ready65", bus.byte_ready_o, 1'b0);
        chk("t3_nodone", done_cnt, d0);
        chk("t3_nowrites", log_data.size(), 0);
        do_start(7'd1);
        chk("t3_err_clr", err, 1'b0);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        bus.byte_valid_i = 1'b0;
        wait_done(d0, "t3_done");
        chk("t3_nwrites", log_data.size(), 1);
        if (log_data.size() == 1) chk("t3_d0", log_data[0], 32'h11223344);
        log_addr.delete(); log_data.delete();

        // 4: gaps in byte_valid; a byte is offered during each WRITE cycle
        d0 = done_cnt;
        do_start(7'd3);
        for (int i = 0; i < 12; i++) begin
            w = exp3[i/4];
            send_byte(w[31-8*(i%4) -: 8]);
            if (gaps[i] != 0) idle_cycles(gaps[i]);
        end
        bus.byte_valid_i = 1'b0;
        wait_done(d0, "t4_done");
        chk("t4_nwrites", log_data.size(), 3);
        if (log_data.size() == 3) begin
            for (int i = 0; i < 3; i++) chk($sformatf("t4_d%0d", i), log_data[i], exp3[i]);
        end
        log_addr.delete(); log_data.delete();

        // 5: full depth, bytes 4*i+k
        d0 = done_cnt;
        do_start(7'd64);
        for (int i = 0; i < 256; i++) send_byte(8'(i));
        bus.byte_valid_i = 1'b0;
        wait_done(d0, "t5_done");
        idle_cycles(4);
        chk("t5_nwrites", log_data.size(), 64);
        chk("t5_one_done", done_cnt, d0 + 1);
        if (log_data.size() == 64) begin
            for (int i = 0; i < 64; i++) begin
                chk($sformatf("t5_a%0d", i), log_addr[i], 32'(i));
                chk($sformatf("t5_d%0d", i), log_data[i],
                    {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)});
            end
        end
        log_addr.delete(); log_data.delete();

        // 6: start pulsed mid-session with len=5 is ignored
        d0 = done_cnt;
        do_start(7'd2);
        send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
        bus.byte_valid_i = 1'b0;
        do_start(7'd5);
        send_byte(8'hA4); send_byte(8'hB1); send_byte(8'hB2);
        send_byte(8'hB3); send_byte(8'hB4);
        bus.byte_valid_i = 1'b0;
        wait_done(d0, "t6_done");
        idle_cycles(3);
        chk("t6_nwrites", log_data.size(), 2);
        chk("t6_ready_end", bus.byte_ready_o, 1'b0);
        if (log_data.size() == 2) begin
            chk("t6_d0", log_data[0], 32'hA1A2A3A4);
            chk("t6_d1", log_data[1], 32'hB1B2B3B4);
        end

        chk("we_with_ready", we_with_ready, 0);
        chk("done_with_busy", done_with_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
